mmu_table_walker: RTL
=====================

# mmu_table_walker

Hardware translation-table walker for the MMU. On a TLB miss it fetches first-level and, if needed, second-level descriptors from the 14-bit word-addressed DRAM port. It returns a 32-bit physical address or a translation fault to the TLB. It sits between the TLB (upstream, request/response) and the DRAM read port (downstream).

## Interface

Parameters:
- TTB_BASE, 14'h1000, first-level table base byte address; must be 1 KB aligned (bits [9:0] zero); only bits [13:10] are used.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- in_req_valid  input  1  TLB miss request; held by the TLB until accepted.
- in_req_vaddr  input  32  virtual address to translate.
- out_req_ready  output  1  high when the walker can accept a request (state IDLE).
- out_resp_valid  output  1  one-cycle pulse; response fields valid in that cycle only.
- out_resp_paddr  output  32  translated physical address; 0 on fault.
- out_resp_fault  output  1  translation fault.
- out_resp_level  output  1  walk level that produced the response: 0 = L1, 1 = L2.
- out_mem_ren  output  1  DRAM read enable.
- out_mem_addr  output  14  DRAM byte address, word aligned.
- out_mem_size  output  2  constant 2'b10 (word).
- in_mem_rdata  input  32  DRAM read data; valid one cycle after the cycle in which out_mem_ren was high.

## Operation

- Request is accepted when in_req_valid && out_req_ready at posedge; vaddr is latched into an internal register (VA).
- Requests presented while not ready are ignored, not queued.
- L1 descriptor address: {TTB_BASE[13:10], VA[31:24], 2'b00}.
- L1 descriptor [1:0]:
  - 2'b10 section: PA = {D[31:24], VA[23:0]}; response with level 0.
  - 2'b01 coarse: L2 walk with L2 table base D[13:10].
  - 2'b00 and 2'b11: fault, level 0.
- L2 descriptor address: {L1D[13:10], VA[23:16], 2'b00}.
- L2 descriptor [1:0]:
  - 2'b10 small page: PA = {D[31:16], VA[15:0]}; response with level 1.
  - Any other value: fault, level 1.
- FSM states: IDLE, L1_RD, L1_WAIT, L2_RD, L2_WAIT, RESP.
  - IDLE -> L1_RD on accept.
  - L1_RD -> L1_WAIT.
  - L1_WAIT -> L2_RD if coarse, else RESP.
  - L2_RD -> L2_WAIT.
  - L2_WAIT -> RESP.
  - RESP -> IDLE.
- out_mem_ren is high only in L1_RD and L2_RD. out_mem_addr holds the descriptor address in those states and 0 otherwise.
- In L1_WAIT and L2_WAIT, in_mem_rdata is sampled into the descriptor register at the posedge.
- RESP drives out_resp_valid = 1 with the registered paddr, fault and level. All response outputs are 0 in every other state.
- The walker never writes DRAM.

## Timing

- Reset: state IDLE; out_req_ready = 1; out_resp_valid, out_resp_paddr, out_resp_fault, out_resp_level, out_mem_ren and out_mem_addr = 0; VA and descriptor registers = 0.
- Cycle numbering: cycle 0 is the cycle in which the request is accepted.
- Section or L1 fault: out_mem_ren high in cycle 1; data sampled at end of cycle 2; out_resp_valid in cycle 3; out_req_ready high again in cycle 4.
- Page or L2 fault: L1 read in cycle 1, L2 read in cycle 3, response in cycle 5, ready in cycle 6.
- out_req_ready is low from cycle 1 through the RESP cycle inclusive.
- No response backpressure: the TLB must consume the pulse.
- in_req_vaddr changes after acceptance do not affect the walk in progress.
- Reset asserted in any state: next cycle is IDLE with reset values. No response is ever emitted for the aborted walk, and no further DRAM read is issued.
- Reset and in_req_valid in the same cycle: reset wins; the request is not accepted.

## Test plan

- Section hit: TTB_BASE = 14'h1000; mem[0x1048] = 0xAB000002; request vaddr 0x12345678 -> out_mem_ren with out_mem_addr 0x1048 in cycle 1; resp_valid in cycle 3 with paddr 0xAB345678, fault 0, level 0.
- Coarse page: mem[0x1048] = 0x00000C01, mem[0x0CD0] = 0xBEEF0002; vaddr 0x12345678 -> reads at 0x1048 (cycle 1) and 0x0CD0 (cycle 3); resp in cycle 5 with paddr 0xBEEF5678, level 1, fault 0.
- Faults: L1 descriptor 0x00000000 -> cycle 3 response with fault 1, level 0, paddr 0. L1 coarse with L2 descriptor 0x00000003 -> cycle 5 response with fault 1, level 1.
- Busy handling: hold in_req_valid high with vaddr changing across a coarse walk -> only the first vaddr is translated; ready is low in cycles 1-5; the second request is accepted in cycle 6.
- Reset mid-walk: assert reset for one cycle in L2_WAIT -> next cycle ready = 1, resp_valid and out_mem_ren = 0; no response pulse follows.
- Reset values: after reset, all outputs are 0 except out_req_ready = 1; out_mem_size = 2'b10 at all times.

Source files
------------

// File: rtl/mmu_table_walker.sv
// mmu_table_walker
//
// Two-level translation-table walker sitting between the TLB and the DRAM
// read port. On a TLB miss it reads the first-level descriptor, optionally
// the second-level descriptor, and returns either a physical address or a
// translation fault together with the level that produced it.
//
// Ports:
//   clock           system clock, all state updates on posedge
//   reset           synchronous active-high reset
//   in_req_valid    TLB miss request, held until accepted
//   in_req_vaddr    virtual address to translate
//   out_req_ready   walker idle and able to accept a request
//   out_resp_valid  single-cycle response pulse
//   out_resp_paddr  translated physical address (0 on fault)
//   out_resp_fault  translation fault
//   out_resp_level  level that produced the response (0 = L1, 1 = L2)
//   out_mem_ren     DRAM read enable
//   out_mem_addr    DRAM byte address of the descriptor (0 when not reading)
//   out_mem_size    access size, always word (2'b10)
//   in_mem_rdata    DRAM read data, valid the cycle after out_mem_ren
//
// All outputs except out_mem_size are registered. They are computed on the
// transition into the state that owns them, so each state presents its
// outputs for the whole cycle it is active.

module mmu_table_walker #(
  parameter logic [13:0] TTB_BASE = 14'h1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_req_valid,
  input  logic [31:0] in_req_vaddr,
  output logic        out_req_ready,
  output logic        out_resp_valid,
  output logic [31:0] out_resp_paddr,
  output logic        out_resp_fault,
  output logic        out_resp_level,
  output logic        out_mem_ren,
  output logic [13:0] out_mem_addr,
  output logic [1:0]  out_mem_size,
  input  logic [31:0] in_mem_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    L1_RD   = 3'd1,
    L1_WAIT = 3'd2,
    L2_RD   = 3'd3,
    L2_WAIT = 3'd4,
    RESP    = 3'd5
  } state_t;

  localparam logic [1:0] L1_COARSE  = 2'b01;
  localparam logic [1:0] L1_SECTION = 2'b10;
  localparam logic [1:0] L2_SMALL   = 2'b10;

  state_t      state;
  logic [31:0] va;
  logic [31:0] desc;

  // Descriptor-address and physical-address formation.
  function automatic logic [13:0] l1_desc_addr(input logic [31:0] vaddr);
    return {TTB_BASE[13:10], vaddr[31:24], 2'b00};
  endfunction

  function automatic logic [13:0] l2_desc_addr(input logic [31:0] l1d,
                                               input logic [31:0] vaddr);
    return {l1d[13:10], vaddr[23:16], 2'b00};
  endfunction

  function automatic logic [31:0] section_pa(input logic [31:0] l1d,
                                             input logic [31:0] vaddr);
    return {l1d[31:24], vaddr[23:0]};
  endfunction

  function automatic logic [31:0] page_pa(input logic [31:0] l2d,
                                          input logic [31:0] vaddr);
    return {l2d[31:16], vaddr[15:0]};
  endfunction

  // The walker only ever reads whole words.
  assign out_mem_size = 2'b10;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      va             <= '0;
      desc           <= '0;
      out_req_ready  <= 1'b1;
      out_resp_valid <= 1'b0;
      out_resp_paddr <= '0;
      out_resp_fault <= 1'b0;
      out_resp_level <= 1'b0;
      out_mem_ren    <= 1'b0;
      out_mem_addr   <= '0;
    end else begin
      case (state)
        // Accept: latch VA so later changes on in_req_vaddr are ignored.
        IDLE: begin
          if (in_req_valid && out_req_ready) begin
            va            <= in_req_vaddr;
            state         <= L1_RD;
            out_req_ready <= 1'b0;
            out_mem_ren   <= 1'b1;
            out_mem_addr  <= l1_desc_addr(in_req_vaddr);
          end
        end

        // L1 read issued this cycle; data returns next cycle.
        L1_RD: begin
          state        <= L1_WAIT;
          out_mem_ren  <= 1'b0;
          out_mem_addr <= '0;
        end

        // L1 descriptor decode.
        L1_WAIT: begin
          desc <= in_mem_rdata;
          case (in_mem_rdata[1:0])
            L1_COARSE: begin
              state        <= L2_RD;
              out_mem_ren  <= 1'b1;
              out_mem_addr <= l2_desc_addr(in_mem_rdata, va);
            end
            L1_SECTION: begin
              state          <= RESP;
              out_resp_valid <= 1'b1;
              out_resp_paddr <= section_pa(in_mem_rdata, va);
              out_resp_fault <= 1'b0;
              out_resp_level <= 1'b0;
            end
            default: begin
              state          <= RESP;
              out_resp_valid <= 1'b1;
              out_resp_paddr <= '0;
              out_resp_fault <= 1'b1;
              out_resp_level <= 1'b0;
            end
          endcase
        end

        // L2 read issued this cycle.
        L2_RD: begin
          state        <= L2_WAIT;
          out_mem_ren  <= 1'b0;
          out_mem_addr <= '0;
        end

        // L2 descriptor decode; anything but a small page faults.
        L2_WAIT: begin
          desc           <= in_mem_rdata;
          state          <= RESP;
          out_resp_valid <= 1'b1;
          out_resp_level <= 1'b1;
          if (in_mem_rdata[1:0] == L2_SMALL) begin
            out_resp_paddr <= page_pa(in_mem_rdata, va);
            out_resp_fault <= 1'b0;
          end else begin
            out_resp_paddr <= '0;
            out_resp_fault <= 1'b1;
          end
        end

        // Response pulse lasts exactly this cycle.
        RESP: begin
          state          <= IDLE;
          out_req_ready  <= 1'b1;
          out_resp_valid <= 1'b0;
          out_resp_paddr <= '0;
          out_resp_fault <= 1'b0;
          out_resp_level <= 1'b0;
        end

        default: begin
          state          <= IDLE;
          out_req_ready  <= 1'b1;
          out_resp_valid <= 1'b0;
          out_resp_paddr <= '0;
          out_resp_fault <= 1'b0;
          out_resp_level <= 1'b0;
          out_mem_ren    <= 1'b0;
          out_mem_addr   <= '0;
        end
      endcase
    end
  end

  // The stored descriptor, the VA section index and several descriptor
  // fields carry no further meaning for the walk once it has been decoded.
  logic unused_bits;
  assign unused_bits = ^{desc, va[31:24], in_mem_rdata[15:14], in_mem_rdata[9:2]};

endmodule
